// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: default geometry and the unpacker state encoding.
// The frame-buffer writer imports the same package.
package fb_pkg;

    localparam int unsigned FRAME_BYTES_DEF = 5100;
    localparam int unsigned IMG_W_DEF       = 240;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } unpack_state_e;

    function automatic int unsigned img_rows(input int unsigned frame_bytes,
                                             input int unsigned img_w);
        return (frame_bytes * 8) / img_w;
    endfunction

endpackage

// File: rtl/pixel_8_unpack_if.sv
// Frame-buffer read port plus pixel stream of the 1-bpp unpacker.
// The master modport is the unpacker side.
interface pixel_8_unpack_if
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int unsigned IMG_W       = IMG_W_DEF
);
    localparam int unsigned AW = $clog2(FRAME_BYTES);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(img_rows(FRAME_BYTES, IMG_W));

    logic          start;
    logic          re;
    logic [AW-1:0] rAddr;
    logic [7:0]    rData;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;
    logic          busy;
    logic          frame_done;

    modport master (
        input  start, rData, pix_ready,
        output re, rAddr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, frame_done
    );

    modport slave (
        output start, rData, pix_ready,
        input  re, rAddr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, frame_done
    );

endinterface

// File: rtl/pixel_xy_counter.sv
// Raster position counter: x runs 0..IMG_W-1, then y advances; y wraps after the
// last row so the count stays inside its field for any geometry.
module pixel_xy_counter #(
    parameter int unsigned IMG_W = 240,
    parameter int unsigned IMG_H = 170,
    localparam int unsigned XW = $clog2(IMG_W),
    localparam int unsigned YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_8_unpack.sv
// Reads a packed 1-bpp frame byte by byte from a synchronous RAM and emits one
// 8-bit pixel per bit (LSB first) over a valid/ready stream with raster position.
module pixel_8_unpack
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int unsigned IMG_W       = IMG_W_DEF
) (
    input logic              clk,
    input logic              reset,
    pixel_8_unpack_if.master bus
);

    localparam int unsigned IMG_H = img_rows(FRAME_BYTES, IMG_W);
    localparam int unsigned AW    = $clog2(FRAME_BYTES);
    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BYTES - 1);

    unpack_state_e state;
    logic [AW-1:0] raddr;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          handshake;
    logic          xy_clear;
    logic [XW-1:0] xpos;
    logic [YW-1:0] ypos;

    assign handshake = (state == S_EMIT) && bus.pix_ready;
    assign xy_clear  = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            raddr   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        raddr   <= '0;
                        bit_cnt <= '0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    // RAM data for the address issued in READ is valid this cycle.
                    shreg   <= bus.rData;
                    bit_cnt <= '0;
                    state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (bus.pix_ready) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (raddr != LAST_ADDR) begin
                            raddr <= raddr + 1'b1;
                            state <= S_READ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    raddr <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    pixel_xy_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_xy (
        .clk     (clk),
        .reset   (reset),
        .clear   (xy_clear),
        .advance (handshake),
        .x       (xpos),
        .y       (ypos)
    );

    always_comb begin
        bus.re         = (state == S_READ);
        bus.rAddr      = raddr;
        bus.pix_valid  = (state == S_EMIT);
        bus.pix_data   = shreg[bit_cnt] ? 8'hFF : 8'h00;
        bus.pix_x      = xpos;
        bus.pix_y      = ypos;
        bus.pix_last   = (state == S_EMIT) && (raddr == LAST_ADDR) && (bit_cnt == 3'd7);
        bus.busy       = (state != S_IDLE);
        bus.frame_done = (state == S_DONE);
    end

endmodule
